// File: rtl/vga_rx_monitor.sv
// Recovers pixel x/y and the video window from monitored VGA sync pins, checks line,
// hsync-width and frame timing, and sums active-area RGB per frame. Optional: PROBE_CAPTURE_EN.
module vga_rx_monitor #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  input  logic        err_clr,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic [11:0] rgb_q,
  output logic        locked,
  output logic [2:0]  err,
  output logic [7:0]  err_cnt,
  output logic [31:0] frame_sum,
  output logic        frame_valid,
  output logic [11:0] probe_rgb
);
  localparam logic [9:0] H_MAX   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] HS_LOAD = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_PRE  = 10'(H_DISPLAY + H_FRONT - 1);
  localparam logic [9:0] HS_END  = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] V_MAX   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] VS_LOAD = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_PRE  = 10'(V_DISPLAY + V_FRONT - 1);
  localparam logic [9:0] HD_C    = 10'(H_DISPLAY);
  localparam logic [9:0] VD_C    = 10'(V_DISPLAY);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [11:0] rgb_d;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [2:0]  err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [31:0] sum_q, sum_d, acc_q, acc_d;
  logic        fv_q, fv_d;

  logic       hs_act, hs_rise, hs_fall, vs_rise, hwrap, active;
  logic [9:0] hcnt_nxt, vcnt_nxt;
  logic [2:0] chk, new_err, err_base;
  logic [7:0] cnt_base;

  // Edges compare the live pin against the level captured on the previous tick.
  always_comb begin
    hs_act   = (hsync == SYNC_POL);
    hs_rise  = hs_act && (hs_q != SYNC_POL);
    hs_fall  = !hs_act && (hs_q == SYNC_POL);
    vs_rise  = (vsync == SYNC_POL) && (vs_q != SYNC_POL);
    hwrap    = (hcnt_q == H_MAX);
    hcnt_nxt = hs_rise ? HS_LOAD : (hwrap ? 10'd0 : hcnt_q + 10'd1);
    vcnt_nxt = vcnt_q;
    if (vs_rise) begin
      vcnt_nxt = VS_LOAD;
    end else if (hwrap && !hs_rise) begin
      vcnt_nxt = (vcnt_q == V_MAX) ? 10'd0 : vcnt_q + 10'd1;
    end
    chk[0]  = hs_rise && (hcnt_q != HS_PRE);
    chk[1]  = hs_fall ? (hcnt_nxt != HS_END) : (hs_act && (hcnt_nxt == HS_END));
    chk[2]  = vs_rise && (vcnt_q != VS_PRE);
    new_err = (state_q != SEARCH) ? chk : 3'b000;
    active  = (hcnt_q < HD_C) && (vcnt_q < VD_C);
  end

  always_comb begin
    state_d   = state_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    rgb_d     = rgb_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    sum_d     = sum_q;
    acc_d     = acc_q;
    fv_d      = 1'b0;
    err_base  = err_clr ? 3'b000 : err_q;
    cnt_base  = err_clr ? 8'd0 : err_cnt_q;
    if (p_tick) begin
      hs_d      = hsync;
      vs_d      = vsync;
      rgb_d     = rgb;
      hcnt_d    = hcnt_nxt;
      vcnt_d    = vcnt_nxt;
      err_d     = err_base;
      err_cnt_d = cnt_base;
      if (new_err != 3'b000) begin
        err_d     = err_base | new_err;
        err_cnt_d = (cnt_base == 8'hFF) ? 8'hFF : cnt_base + 8'd1;
        state_d   = SEARCH;
        acc_d     = '0;
      end else begin
        case (state_q)
          SEARCH: begin
            acc_d = '0;
            if (vs_rise) state_d = ACQUIRE;
          end
          ACQUIRE, LOCKED: begin
            if (vs_rise) begin
              sum_d   = acc_q;
              fv_d    = 1'b1;
              acc_d   = '0;
              state_d = LOCKED;
            end else if (active) begin
              acc_d = acc_q + {20'd0, rgb_q};
            end
          end
          default: state_d = SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      hs_q      <= !SYNC_POL;
      vs_q      <= !SYNC_POL;
      rgb_q     <= '0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      err_q     <= '0;
      err_cnt_q <= '0;
      sum_q     <= '0;
      acc_q     <= '0;
      fv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      rgb_q     <= rgb_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      sum_q     <= sum_d;
      acc_q     <= acc_d;
      fv_q      <= fv_d;
    end
  end

  assign x           = hcnt_q;
  assign y           = vcnt_q;
  assign locked      = (state_q == LOCKED);
  assign video_on    = locked && active;
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;
  assign frame_sum   = sum_q;
  assign frame_valid = fv_q;

`ifdef PROBE_CAPTURE_EN
  logic [11:0] probe_q, probe_d;

  always_comb begin
    probe_d = probe_q;
    if (p_tick && locked && (hcnt_q == probe_x) && (vcnt_q == probe_y)) probe_d = rgb_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) probe_q <= '0;
    else        probe_q <= probe_d;
  end

  assign probe_rgb = probe_q;
`else
  logic unused_probe;
  assign unused_probe = ^{probe_x, probe_y};
  assign probe_rgb    = '0;
`endif
endmodule
